// File: rtl/br_resolve_pkg.sv
// Shared types and constants for the branch-resolution slice.
// Holds the FSM encoding, the prediction record layout and a saturating-increment helper.
package br_resolve_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    localparam logic [31:0] FETCH_STRIDE = 32'd8;

    typedef struct packed {
        logic [31:0] fetch_pc;
        logic [31:0] pred_pc;
        logic        pred_taken;
    } pred_rec_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/br_pred_fifo.sv
// Circular FIFO of in-flight prediction records with a flush that empties it.
// Pointers carry one extra wrap bit to tell full from empty.
module br_pred_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/br_resolve.sv
// Compares EX branch outcomes against queued predictions, emits predictor updates,
// redirects the front end on a target mispredict and keeps saturating statistics.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    output logic        pred_ready,
    input  logic [31:0] pred_fetch_pc,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_taken,
    input  logic [31:0] ex_tpc,
    output logic        fact_valid,
    output logic [31:0] fact_pc,
    output logic [31:0] fact_tpc,
    output logic        fact_taken,
    output logic        predict_dir_fail,
    output logic        predict_add_fail,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        err_underflow,
    output logic [31:0] cnt_total,
    output logic [31:0] cnt_dir_fail,
    output logic [31:0] cnt_add_fail
);

    state_e    r_state;
    pred_rec_t w_head;
    pred_rec_t w_wrec;
    logic      w_full;
    logic      w_empty;
    logic      w_pop;
    logic      w_push;
    logic      w_underflow;
    logic      w_dir_fail;
    logic      w_add_fail;
    logic      w_mispredict;
    logic [31:0] w_actual_next;

    assign w_pop         = ex_valid && !w_empty && (r_state == ST_RUN);
    assign w_underflow   = ex_valid && w_empty && (r_state == ST_RUN);
    assign w_actual_next = ex_taken ? ex_tpc : w_head.fetch_pc + FETCH_STRIDE;
    assign w_dir_fail    = w_head.pred_taken != ex_taken;
    assign w_add_fail    = w_head.pred_pc != w_actual_next;
    assign w_mispredict  = w_pop && w_add_fail;
    // A mispredicting pop flushes the queue, so any concurrent push is refused.
    assign pred_ready    = !w_full && (r_state == ST_RUN) && !w_mispredict;
    assign w_push        = pred_valid && pred_ready;
    assign w_wrec        = '{fetch_pc: pred_fetch_pc, pred_pc: pred_pc, pred_taken: pred_taken};

    br_pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pred_rec_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_mispredict),
        .i_push  (w_push),
        .i_wdata (w_wrec),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_RUN;
            fact_valid       <= 1'b0;
            fact_pc          <= '0;
            fact_tpc         <= '0;
            fact_taken       <= 1'b0;
            predict_dir_fail <= 1'b0;
            predict_add_fail <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            err_underflow    <= 1'b0;
            cnt_total        <= '0;
            cnt_dir_fail     <= '0;
            cnt_add_fail     <= '0;
        end else begin
            fact_valid     <= w_pop;
            redirect_valid <= w_mispredict;
            if (w_pop) begin
                fact_pc          <= w_head.fetch_pc;
                fact_tpc         <= w_actual_next;
                fact_taken       <= ex_taken;
                predict_dir_fail <= w_dir_fail;
                predict_add_fail <= w_add_fail;
                cnt_total        <= sat_inc(cnt_total);
                if (w_dir_fail) cnt_dir_fail <= sat_inc(cnt_dir_fail);
                if (w_add_fail) cnt_add_fail <= sat_inc(cnt_add_fail);
            end
            if (w_mispredict) redirect_pc <= w_actual_next;
            if (w_underflow) err_underflow <= 1'b1;
            case (r_state)
                ST_RUN:     if (w_mispredict) r_state <= ST_RECOVER;
                ST_RECOVER: r_state <= ST_RUN;
                default:    r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 Parameter DEPTH, default 8, power of two ≥2; number of in-flight fetch-packet prediction records.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 pred_valid  in  1  fetch offers a prediction record this cycle.
REQ-005 pred_ready  out  1  queue accepts a record this cycle.
REQ-006 pred_fetch_pc / pred_pc  in  32 each  fetch packet PC / predicted next PC from the branch predictor.
REQ-007 pred_taken  in  1  predicted direction.
REQ-008 ex_valid  in  1  EX resolves the oldest outstanding packet this cycle.
REQ-009 ex_taken  in  1  actual direction; ex_tpc  in  32  actual target, meaningful only when ex_taken=1.
REQ-010 fact_valid  out  1  one-cycle strobe; predictor update fields are valid.
REQ-011 fact_pc / fact_tpc  out  32 each; fact_taken, predict_dir_fail, predict_add_fail  out  1 each  predictor update bus.
REQ-012 redirect_valid  out  1; redirect_pc  out  32  front-end redirect on mispredict.
REQ-013 err_underflow  out  1  sticky: ex_valid seen with the queue empty.
REQ-014 cnt_total, cnt_dir_fail, cnt_add_fail  out  32 each  saturating statistics.

Function
REQ-015 The queue SHALL be a circular FIFO of DEPTH records {fetch_pc, pred_pc, pred_taken}, with read/write pointers log2(DEPTH)+1 bits wide; full = indices equal and MSBs differ; empty = pointers equal.
REQ-016 Push occurs when pred_valid && pred_ready; pred_ready = !full && state==RUN && !mispredict-this-cycle.
REQ-017 Pop occurs when ex_valid && !empty; push and pop in the same non-full cycle SHALL both take effect, leaving occupancy unchanged; no bypass of a full queue.
REQ-018 actual_next = ex_taken ? ex_tpc : head.fetch_pc+8, computed modulo 2^32.
REQ-019 dir_fail = head.pred_taken != ex_taken; add_fail = head.pred_pc != actual_next; mispredict = add_fail.
REQ-020 Outputs SHALL be registered, latency 1 cycle after the pop: fact_valid=1, fact_pc=head.fetch_pc, fact_tpc=actual_next, fact_taken=ex_taken, predict_dir_fail=dir_fail, predict_add_fail=add_fail.
REQ-021 On a mispredicting pop, the next cycle SHALL assert redirect_valid=1 with redirect_pc=actual_next for exactly one cycle, and the queue SHALL be emptied (wrong-path records discarded) in the same edge as the pop.
REQ-022 FSM states RUN and RECOVER; RUN→RECOVER on a mispredicting pop; RECOVER→RUN unconditionally after one cycle; pred_ready=0 and ex_valid ignored in RECOVER.
REQ-023 A push coinciding with a mispredicting pop SHALL be dropped (flush wins).
REQ-024 ex_valid with the queue empty in RUN SHALL set err_underflow and produce no fact_valid or redirect.
REQ-025 Each pop increments cnt_total; dir_fail increments cnt_dir_fail; add_fail increments cnt_add_fail; all saturate at 0xFFFFFFFF.
REQ-026 When no pop occurs, fact_valid and redirect_valid SHALL be 0; data fields hold their last values.

Reset
REQ-027 rst SHALL set both pointers to 0, state to RUN, fact_valid=0, redirect_valid=0, all fact/redirect data to 0, err_underflow=0, and all counters to 0.
REQ-028 rst asserted mid-operation SHALL discard all queued records; record storage need not be cleared.

Structure
REQ-029 Shared package holds FSM state encodings (RUN=1'b0, RECOVER=1'b1) and the fetch-packet stride constant (8).
REQ-030 One sub-module, br_pred_fifo (parameterised circular FIFO with flush input), SHALL hold the record storage and pointers; comparison, FSM and counters stay in br_resolve.

Verification
REQ-031 Push {0x1C000000, 0x1C000008, 0}; ex_valid ex_taken=0 -> next cycle fact_valid=1, dir_fail=0, add_fail=0, no redirect, cnt_total=1.
REQ-032 Push {0x1C000010, 0x1C000018, 0}; ex_taken=1, ex_tpc=0x1C000100 -> dir_fail=1, add_fail=1, redirect_pc=0x1C000100, queue empty, pred_ready=0 for one cycle.
REQ-033 Push {0x1C000020, 0x1C000040, 1}; ex_taken=1, ex_tpc=0x1C000080 -> dir_fail=0, add_fail=1, redirect to 0x1C000080.
REQ-034 Push DEPTH records without pops -> pred_ready=0; simultaneous pop+push at DEPTH-1 occupancy keeps occupancy; pointer wrap after 2·DEPTH pushes preserves FIFO order.
REQ-035 ex_valid on an empty queue -> err_underflow=1 sticky, fact_valid stays 0; rst then clears it.
REQ-036 Mispredicting pop with pred_valid=1 in the same cycle -> pushed record absent; following ex_valid in RECOVER ignored.
